// File: rtl/muldiv_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl_pkg
// Shared definitions for the HI/LO multiply/divide sequencer: operation codes,
// FSM state encodings, fixed widths and a small magnitude helper.
// -----------------------------------------------------------------------------
package muldiv_ctrl_pkg;

    localparam int MD_WIDTH  = 32;
    localparam int MD_OP_W   = 3;
    localparam int MD_CNT_W  = 6;

    // Operation codes carried on the op port; 6 and 7 are reserved.
    typedef enum logic [MD_OP_W-1:0] {
        MD_OP_MULT  = 3'd0,
        MD_OP_MULTU = 3'd1,
        MD_OP_DIV   = 3'd2,
        MD_OP_DIVU  = 3'd3,
        MD_OP_MTHI  = 3'd4,
        MD_OP_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        MD_ST_IDLE    = 2'd0,
        MD_ST_MUL     = 2'd1,
        MD_ST_DIV_RUN = 2'd2,
        MD_ST_DIV_FIX = 2'd3
    } md_state_e;

    // Magnitude of a two's complement word. 0x80000000 maps to itself, which
    // is the correct unsigned magnitude for the divider.
    function automatic logic [MD_WIDTH-1:0] md_abs(input logic [MD_WIDTH-1:0] v);
        logic [MD_WIDTH-1:0] r;
        if (v[MD_WIDTH-1]) begin
            r = (~v) + {{(MD_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_div_core.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl_div_core
// One combinational radix-2 restoring division step.
// Ports: rem, quo (current partial remainder / quotient shift register),
//        divisor (magnitude), rem_next, quo_next (state after this step).
// -----------------------------------------------------------------------------
module muldiv_ctrl_div_core #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] rem_sh_s;
    logic [WIDTH:0] diff_s;

    // Shift {rem,quo} left one bit and trial-subtract; the extra top bit of
    // the shifted remainder keeps the comparison exact.
    always_comb begin
        rem_sh_s = {rem, quo[WIDTH-1]};
        diff_s   = rem_sh_s - {1'b0, divisor};
        if (diff_s[WIDTH]) begin
            rem_next = rem_sh_s[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end else begin
            rem_next = diff_s[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/multiplier.sv
// -----------------------------------------------------------------------------
// multiplier
// Combinational WIDTH x WIDTH -> 2*WIDTH multiplier, signed or unsigned.
// Ports: a, b (operands), is_signed (treat operands as two's complement),
//        product (full double-width result).
// -----------------------------------------------------------------------------
module multiplier #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic [2*WIDTH-1:0] product
);

    logic [2*WIDTH-1:0] ext_a_s;
    logic [2*WIDTH-1:0] ext_b_s;

    // Extending both operands to the full result width makes the low
    // 2*WIDTH bits of a plain product correct for both signednesses.
    always_comb begin
        ext_a_s = {{WIDTH{is_signed & a[WIDTH-1]}}, a};
        ext_b_s = {{WIDTH{is_signed & b[WIDTH-1]}}, b};
        product = ext_a_s * ext_b_s;
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl
// Owns architectural HI/LO and sequences MULT/MULTU (one registered multiply
// cycle), DIV/DIVU (32-step restoring divide plus sign fix-up) and MTHI/MTLO.
// Ports: clk, resetn (synchronous, active low), start/op/src_a/src_b (request,
//        sampled only when idle), flush (abort in-flight op), busy (stall),
//        done (pulse in the cycle after HI/LO is written), hi, lo.
// -----------------------------------------------------------------------------
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_e             state_r;
    logic [MD_CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]      hi_r;
    logic [WIDTH-1:0]      lo_r;
    logic                  busy_r;
    logic                  done_r;
    logic [WIDTH-1:0]      mul_a_r;
    logic [WIDTH-1:0]      mul_b_r;
    logic                  mul_signed_r;
    logic [WIDTH-1:0]      rem_r;
    logic [WIDTH-1:0]      quo_r;
    logic [WIDTH-1:0]      div_b_r;
    logic                  fix_signed_r;
    logic                  neg_quo_r;
    logic                  neg_rem_r;

    md_op_e                op_s;
    logic                  div_signed_s;
    logic [2*WIDTH-1:0]    product_s;
    logic [WIDTH-1:0]      rem_next_s;
    logic [WIDTH-1:0]      quo_next_s;
    logic [WIDTH-1:0]      quo_fixed_s;
    logic [WIDTH-1:0]      rem_fixed_s;

    assign op_s = md_op_e'(op);

    multiplier #(.WIDTH(WIDTH)) u_multiplier (
        .a         (mul_a_r),
        .b         (mul_b_r),
        .is_signed (mul_signed_r),
        .product   (product_s)
    );

    muldiv_ctrl_div_core #(.WIDTH(WIDTH)) u_div_core (
        .rem      (rem_r),
        .quo      (quo_r),
        .divisor  (div_b_r),
        .rem_next (rem_next_s),
        .quo_next (quo_next_s)
    );

    // Sign fix-up applied in DIV_FIX; divide-by-zero clears fix_signed_r so
    // its raw 0xFFFFFFFF / dividend result passes through untouched.
    always_comb begin
        div_signed_s = (op_s == MD_OP_DIV);
        if (fix_signed_r && neg_quo_r) begin
            quo_fixed_s = (~quo_r) + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            quo_fixed_s = quo_r;
        end
        if (fix_signed_r && neg_rem_r) begin
            rem_fixed_s = (~rem_r) + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            rem_fixed_s = rem_r;
        end
    end

    // Sequencer FSM with registered HI/LO, busy and done.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r      <= MD_ST_IDLE;
            cnt_r        <= {MD_CNT_W{1'b0}};
            hi_r         <= {WIDTH{1'b0}};
            lo_r         <= {WIDTH{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            mul_a_r      <= {WIDTH{1'b0}};
            mul_b_r      <= {WIDTH{1'b0}};
            mul_signed_r <= 1'b0;
            rem_r        <= {WIDTH{1'b0}};
            quo_r        <= {WIDTH{1'b0}};
            div_b_r      <= {WIDTH{1'b0}};
            fix_signed_r <= 1'b0;
            neg_quo_r    <= 1'b0;
            neg_rem_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                MD_ST_IDLE: begin
                    // start is honoured only when no flush accompanies it
                    if (start && !flush) begin
                        case (op_s)
                            MD_OP_MTHI: begin
                                hi_r   <= src_a;
                                done_r <= 1'b1;
                            end
                            MD_OP_MTLO: begin
                                lo_r   <= src_a;
                                done_r <= 1'b1;
                            end
                            MD_OP_MULT, MD_OP_MULTU: begin
                                mul_a_r      <= src_a;
                                mul_b_r      <= src_b;
                                mul_signed_r <= (op_s == MD_OP_MULT);
                                state_r      <= MD_ST_MUL;
                                busy_r       <= 1'b1;
                            end
                            MD_OP_DIV, MD_OP_DIVU: begin
                                busy_r <= 1'b1;
                                if (src_b == {WIDTH{1'b0}}) begin
                                    quo_r        <= {WIDTH{1'b1}};
                                    rem_r        <= src_a;
                                    fix_signed_r <= 1'b0;
                                    state_r      <= MD_ST_DIV_FIX;
                                end else begin
                                    quo_r        <= div_signed_s ? md_abs(src_a) : src_a;
                                    div_b_r      <= div_signed_s ? md_abs(src_b) : src_b;
                                    neg_rem_r    <= src_a[WIDTH-1];
                                    neg_quo_r    <= src_a[WIDTH-1] ^ src_b[WIDTH-1];
                                    fix_signed_r <= div_signed_s;
                                    rem_r        <= {WIDTH{1'b0}};
                                    cnt_r        <= {MD_CNT_W{1'b0}};
                                    state_r      <= MD_ST_DIV_RUN;
                                end
                            end
                            default: begin
                                state_r <= MD_ST_IDLE;
                            end
                        endcase
                    end else begin
                        state_r <= MD_ST_IDLE;
                    end
                end
                MD_ST_MUL: begin
                    state_r <= MD_ST_IDLE;
                    busy_r  <= 1'b0;
                    if (!flush) begin
                        hi_r   <= product_s[2*WIDTH-1:WIDTH];
                        lo_r   <= product_s[WIDTH-1:0];
                        done_r <= 1'b1;
                    end else begin
                        done_r <= 1'b0;
                    end
                end
                MD_ST_DIV_RUN: begin
                    if (flush) begin
                        state_r <= MD_ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        rem_r <= rem_next_s;
                        quo_r <= quo_next_s;
                        cnt_r <= cnt_r + 6'd1;
                        // cnt_r==31 here is the 32nd step
                        if (cnt_r == 6'd31) begin
                            state_r <= MD_ST_DIV_FIX;
                        end else begin
                            state_r <= MD_ST_DIV_RUN;
                        end
                    end
                end
                MD_ST_DIV_FIX: begin
                    state_r <= MD_ST_IDLE;
                    busy_r  <= 1'b0;
                    if (!flush) begin
                        lo_r   <= quo_fixed_s;
                        hi_r   <= rem_fixed_s;
                        done_r <= 1'b1;
                    end else begin
                        done_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= MD_ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule
